fpu_instr_deserializer: RTL and testbench

- Producer side of the FPU instruction interface: rebuilds a packed fpu_instruction_t from a byte-wide valid/ready stream and presents it to the FPU core with a valid/ready handshake.
- Sits between the host/UART byte link and the FPU issue port.
- Checks each instruction's opcode, drops illegal or truncated instructions, and reports them with error pulses and counters.

---
 rtl/fpu_instr_deserializer_pkg.sv | 48 ++++
 rtl/fpu_deser_timeout.sv | 35 +++
 rtl/fpu_instr_deserializer.sv | 178 +++++++++++++++++
 tb/tb_fpu_instr_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_instr_deserializer_pkg.sv
// Shared FPU instruction types plus the byte-stream deserializer definitions.
package fpu_instr_deserializer_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MULT = 3'd2,
    DIV  = 3'd3
  } fpu_op_t;

  typedef enum logic [1:0] {
    round_nearest_even = 2'd0,
    round_to_zero      = 2'd1,
    round_up           = 2'd2,
    round_down         = 2'd3
  } rmode_t;

  typedef logic [31:0] float_t;

  typedef struct packed {
    fpu_op_t fpu_op;
    rmode_t  rmode;
    float_t  opa;
    float_t  opb;
  } fpu_instruction_t;

  localparam int unsigned FPU_INSTR_BYTES = 9;
  localparam int unsigned OPERAND_BYTES   = (FPU_INSTR_BYTES - 1) / 2;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BAD_OP  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_t;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    OPA  = 2'd1,
    OPB  = 2'd2,
    HOLD = 2'd3
  } deser_state_t;

  // Only the four arithmetic ops are implemented by the core.
  function automatic logic op_is_legal(logic [7:0] hdr);
    return hdr[7:5] <= 3'd3;
  endfunction

endpackage

// File: rtl/fpu_deser_timeout.sv
// Idle-cycle counter; expired_o flags the idle cycle that reaches TIMEOUT_CYCLES.
module fpu_deser_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !clear_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_instr_deserializer.sv
// Rebuilds fpu_instruction_t from a 9-byte stream and issues it with valid/ready.
module fpu_instr_deserializer
  import fpu_instr_deserializer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic [68:0]      instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] instr_count_o,
  output logic [7:0]       err_count_o
);

  deser_state_t     state_q, state_d;
  fpu_op_t          op_q;
  rmode_t           rmode_q;
  float_t           opa_q, opb_q;
  logic [1:0]       idx_q;
  logic             rdy_en_q;
  logic             err_q;
  err_code_t        err_code_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [7:0]       err_cnt_q;

  logic xfer, in_op, expired, hdr_ok, idx_last;
  logic load_hdr, bad_op, shift_a, shift_b, abort, deliver;

  assign xfer     = byte_valid_i & byte_ready_o;
  assign in_op    = (state_q == OPA) || (state_q == OPB);
  assign hdr_ok   = op_is_legal(byte_i);
  assign idx_last = (idx_q == 2'(OPERAND_BYTES - 1));

  fpu_deser_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (xfer | ~in_op),
    .en_i     (in_op),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_hdr = 1'b0;
    bad_op   = 1'b0;
    shift_a  = 1'b0;
    shift_b  = 1'b0;
    abort    = 1'b0;
    deliver  = 1'b0;
    unique case (state_q)
      HDR: begin
        if (xfer) begin
          if (hdr_ok) begin
            load_hdr = 1'b1;
            state_d  = OPA;
          end else begin
            bad_op = 1'b1;
          end
        end
      end
      OPA: begin
        if (expired) begin
          abort   = 1'b1;
          state_d = HDR;
        end else if (xfer) begin
          shift_a = 1'b1;
          if (idx_last) state_d = OPB;
        end
      end
      OPB: begin
        if (expired) begin
          abort   = 1'b1;
          state_d = HDR;
        end else if (xfer) begin
          shift_b = 1'b1;
          if (idx_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready_i) begin
          deliver = 1'b1;
          state_d = HDR;
          // A byte accepted alongside the output handshake is the next header.
          if (xfer) begin
            if (hdr_ok) begin
              load_hdr = 1'b1;
              state_d  = OPA;
            end else begin
              bad_op = 1'b1;
            end
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_comb begin
    byte_ready_o  = 1'b0;
    instr_valid_o = 1'b0;
    unique case (state_q)
      HDR, OPA, OPB: byte_ready_o = rdy_en_q;
      HOLD: begin
        byte_ready_o  = instr_ready_i;
        instr_valid_o = 1'b1;
      end
      default: byte_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= ADD;
      rmode_q     <= round_nearest_even;
      opa_q       <= '0;
      opb_q       <= '0;
      idx_q       <= '0;
      rdy_en_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      instr_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      err_q    <= bad_op | abort;
      if (bad_op) begin
        err_code_q <= ERR_BAD_OP;
      end else if (abort) begin
        err_code_q <= ERR_TIMEOUT;
      end
      if ((bad_op || abort) && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (deliver) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
      if (abort) begin
        op_q    <= ADD;
        rmode_q <= round_nearest_even;
        opa_q   <= '0;
        opb_q   <= '0;
        idx_q   <= '0;
      end else if (load_hdr) begin
        op_q    <= fpu_op_t'(byte_i[7:5]);
        rmode_q <= rmode_t'(byte_i[4:3]);
        idx_q   <= '0;
      end else if (shift_a || shift_b) begin
        if (shift_a) opa_q <= {opa_q[23:0], byte_i};
        if (shift_b) opb_q <= {opb_q[23:0], byte_i};
        idx_q <= idx_last ? 2'd0 : idx_q + 2'd1;
      end
    end
  end

  assign instr_o       = {op_q, rmode_q, opa_q, opb_q};
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign instr_count_o = instr_cnt_q;
  assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_fpu_instr_deserializer.sv
// Directed bench: table of instructions plus backpressure, timeout, reset and counter sequences.
module tb_fpu_instr_deserializer;

  localparam int unsigned TO = 64;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic [68:0]   instr_o;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [CW-1:0] instr_count_o;
  logic [7:0]    err_count_o;

  fpu_instr_deserializer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .instr_count_o(instr_count_o),
    .err_count_o  (err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] bytes;
    int          nbytes;
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[7];
  int   legal_idx[5] = '{0, 2, 3, 5, 6};
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_icnt = 0;
  int   exp_ecnt = 0;

  function automatic vec_t mk(logic [71:0] b, int n, logic [2:0] op, logic [1:0] rm,
                              logic [31:0] a, logic [31:0] bb);
    vec_t v;
    v.bytes = b; v.nbytes = n; v.op = op; v.rm = rm; v.a = a; v.b = bb;
    return v;
  endfunction

  function automatic logic [68:0] exp_instr(vec_t v);
    return {v.op, v.rm, v.a, v.b};
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    #1 check("byte_ready", 69'(byte_ready_o), 69'd1);
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_from(input vec_t v, input int first);
    for (int i = first; i < v.nbytes; i++) send_byte(v.bytes[71-8*i -: 8]);
  endtask

  task automatic apply_vec(input vec_t v);
    instr_ready_i = 1'b1;
    send_from(v, 0);
    if (v.nbytes == 1) begin
      exp_ecnt = (exp_ecnt < 255) ? exp_ecnt + 1 : 255;
      check("bad_err", 69'(err_o), 69'd1);
      check("bad_code", 69'(err_code_o), 69'd1);
      check("bad_ecnt", 69'(err_count_o), 69'(exp_ecnt));
      check("bad_novalid", 69'(instr_valid_o), 69'd0);
      @(negedge clk);
      check("bad_pulse", 69'(err_o), 69'd0);
    end else begin
      check("valid", 69'(instr_valid_o), 69'd1);
      check("instr", instr_o, exp_instr(v));
      @(negedge clk);
      exp_icnt = (exp_icnt + 1) % 16;
      check("valid_1cyc", 69'(instr_valid_o), 69'd0);
      check("icnt", 69'(instr_count_o), 69'(exp_icnt));
      check("no_err", 69'(err_o), 69'd0);
    end
  endtask

  initial begin
    vec_t prev;
    vec_t cur;
    vecs[0] = mk(72'h40_3F800000_40000000, 9, 3'd2, 2'd0, 32'h3F800000, 32'h40000000);
    vecs[1] = mk(72'hE0_00000000_00000000, 1, 3'd7, 2'd0, 32'h0, 32'h0);
    vecs[2] = mk(72'h00_12345678_9ABCDEF0, 9, 3'd0, 2'd0, 32'h12345678, 32'h9ABCDEF0);
    vecs[3] = mk(72'h3F_DEADBEEF_00000001, 9, 3'd1, 2'd3, 32'hDEADBEEF, 32'h00000001);
    vecs[4] = mk(72'h9F_00000000_00000000, 1, 3'd4, 2'd3, 32'h0, 32'h0);
    vecs[5] = mk(72'h70_FFFFFFFF_80000000, 9, 3'd3, 2'd2, 32'hFFFFFFFF, 32'h80000000);
    vecs[6] = mk(72'h68_7F7FFFFF_00800000, 9, 3'd3, 2'd1, 32'h7F7FFFFF, 32'h00800000);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 69'(byte_ready_o), 69'd0);
    check("rst_valid", 69'(instr_valid_o), 69'd0);
    check("rst_instr", instr_o, 69'd0);
    check("rst_err", 69'(err_o), 69'd0);
    check("rst_code", 69'(err_code_o), 69'd0);
    check("rst_icnt", 69'(instr_count_o), 69'd0);
    check("rst_ecnt", 69'(err_count_o), 69'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 69'(byte_ready_o), 69'd1);

    for (int v = 0; v < 7; v++) apply_vec(vecs[v]);

    // Backpressure in HOLD; header 00 waits until the handshake cycle
    instr_ready_i = 1'b0;
    send_from(vecs[0], 0);
    byte_i       = 8'h00;
    byte_valid_i = 1'b1;
    repeat (5) begin
      #1;
      check("bp_ready", 69'(byte_ready_o), 69'd0);
      check("bp_valid", 69'(instr_valid_o), 69'd1);
      check("bp_instr", instr_o, exp_instr(vecs[0]));
      @(negedge clk);
    end
    instr_ready_i = 1'b1;
    #1 check("bp_ready_pass", 69'(byte_ready_o), 69'd1);
    @(negedge clk);
    byte_valid_i = 1'b0;
    exp_icnt = (exp_icnt + 1) % 16;
    check("bp_valid_drop", 69'(instr_valid_o), 69'd0);
    check("bp_icnt", 69'(instr_count_o), 69'(exp_icnt));
    send_from(vecs[2], 1);
    check("bp_next_valid", 69'(instr_valid_o), 69'd1);
    check("bp_next_instr", instr_o, exp_instr(vecs[2]));
    @(negedge clk);
    exp_icnt = (exp_icnt + 1) % 16;
    check("bp_next_icnt", 69'(instr_count_o), 69'(exp_icnt));

    // Timeout after header + 2 opa bytes
    send_byte(8'h40);
    send_byte(8'h3F);
    send_byte(8'h80);
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      if (n == TO - 1) check("to_early", 69'(err_o), 69'd0);
    end
    exp_ecnt++;
    check("to_err", 69'(err_o), 69'd1);
    check("to_code", 69'(err_code_o), 69'd2);
    check("to_ecnt", 69'(err_count_o), 69'(exp_ecnt));
    check("to_novalid", 69'(instr_valid_o), 69'd0);
    @(negedge clk);
    check("to_pulse", 69'(err_o), 69'd0);
    check("to_code_held", 69'(err_code_o), 69'd2);
    apply_vec(vecs[5]);

    // Asynchronous reset while holding an instruction
    instr_ready_i = 1'b0;
    send_from(vecs[3], 0);
    #1 check("hold_valid", 69'(instr_valid_o), 69'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 69'(instr_valid_o), 69'd0);
    check("arst_instr", instr_o, 69'd0);
    check("arst_icnt", 69'(instr_count_o), 69'd0);
    check("arst_ecnt", 69'(err_count_o), 69'd0);
    check("arst_code", 69'(err_code_o), 69'd0);
    check("arst_ready", 69'(byte_ready_o), 69'd0);
    exp_icnt = 0;
    exp_ecnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_vec(vecs[0]);

    // err_count_o saturation over 256 back-to-back illegal headers
    instr_ready_i = 1'b1;
    byte_i        = 8'hE0;
    byte_valid_i  = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 255) check("sat_255", 69'(err_count_o), 69'd255);
    end
    byte_valid_i = 1'b0;
    check("sat_256", 69'(err_count_o), 69'd255);
    check("sat_err", 69'(err_o), 69'd1);
    exp_ecnt = 255;

    // 16 gapless instructions: instr_count_o wraps at 2^CW
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      cur = vecs[legal_idx[k % 5]];
      for (int i = 0; i < 9; i++) begin
        if (k > 0 && i == 0) begin
          check("b2b_valid", 69'(instr_valid_o), 69'd1);
          check("b2b_instr", instr_o, exp_instr(prev));
          exp_icnt = (exp_icnt + 1) % 16;
        end
        send_byte(cur.bytes[71-8*i -: 8]);
      end
      prev = cur;
    end
    check("b2b_last_valid", 69'(instr_valid_o), 69'd1);
    check("b2b_last_instr", instr_o, exp_instr(prev));
    @(negedge clk);
    exp_icnt = (exp_icnt + 1) % 16;
    check("wrap_icnt", 69'(instr_count_o), 69'(exp_icnt));
    check("wrap_ecnt", 69'(err_count_o), 69'(exp_ecnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
